mem_tile_resp: RTL



---
 rtl/mem_tile_resp_pkg.sv | 24 ++
 rtl/mem_tile_resp_ram.sv | 35 +++
 rtl/mem_tile_resp.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_tile_resp_pkg.sv
// Shared tile-memory bus definitions: request opcodes, response codes and filler values
// used by the mem_tile_resp responder.
package mem_tile_resp_pkg;

    localparam logic [4:0] UMEM_OPM_READY   = 5'b00000;
    localparam logic [4:0] UMEM_OPM_RD_TILE = 5'b01111;
    localparam logic [4:0] UMEM_OPM_WR_TILE = 5'b10111;

    localparam logic [1:0] UMEM_OK_READY = 2'b00;
    localparam logic [1:0] UMEM_OK_OK    = 2'b01;
    localparam logic [1:0] UMEM_OK_HOLD  = 2'b10;
    localparam logic [1:0] UMEM_OK_FAULT = 2'b11;

    // Don't-care filler for data buses that carry nothing meaningful this cycle.
    localparam logic [127:0] UV128_XX = 128'h0;

    localparam int TILE_W = 128;
    localparam int HALF_W = 64;

    function automatic logic is_tile_req(input logic [4:0] opm);
        return (opm == UMEM_OPM_RD_TILE) || (opm == UMEM_OPM_WR_TILE);
    endfunction

endpackage

// File: rtl/mem_tile_resp_ram.sv
// Tile store for mem_tile_resp: 2^AW x 128 single-port synchronous RAM with a write
// enable per 64-bit half. The read register only updates on a pure read access.
module mem_tile_resp_ram
    import mem_tile_resp_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic [1:0]        we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [TILE_W-1:0] wdata_i,
    output logic [TILE_W-1:0] rdata_o
);

    logic [TILE_W-1:0] mem_q [2**AW];
    logic [TILE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i[0]) begin
                mem_q[addr_i][HALF_W-1:0] <= wdata_i[HALF_W-1:0];
            end
            if (we_i[1]) begin
                mem_q[addr_i][TILE_W-1:HALF_W] <= wdata_i[TILE_W-1:HALF_W];
            end
            if (we_i == 2'b00) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_tile_resp.sv
// Tile memory bus responder: answers RD_TILE/WR_TILE with READY/HOLD/OK after LATENCY cycles.
// Define MEM_TILE_RESP_BL64_EN for 64-bit transfers (memAddr[3] selects the tile half).
module mem_tile_resp
    import mem_tile_resp_pkg::*;
#(
    parameter int IXW     = 10,
    parameter int LATENCY = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        memAddr,
    input  logic [4:0]         memOpm,
    input  logic [TILE_W-1:0]  memDataIn,
    output logic [TILE_W-1:0]  memDataOut,
    output logic [1:0]         memOK,
    output logic [1:0]         dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [IXW-1:0]      ix_q, ix_d;
    logic                wr_q, wr_d;
    logic [TILE_W-1:0]   data_q, data_d;
    logic [TILE_W-1:0]   dout_q, dout_d;
    logic [1:0]          ok_q, ok_d;
    logic                half_q, half_d;

    logic                ram_en;
    logic [1:0]          ram_we;
    logic [IXW-1:0]      ram_addr;
    logic [TILE_W-1:0]   ram_wdata;
    logic [TILE_W-1:0]   ram_rdata;

    logic [IXW-1:0]      req_ix;
    logic [TILE_W-1:0]   req_data;
    logic                req_half;
    logic                unused_bits;

    // Higher address bits alias onto the store; no range fault is raised.
    assign req_ix = memAddr[IXW+3:4];

`ifdef MEM_TILE_RESP_BL64_EN
    assign req_half    = memAddr[3];
    assign req_data    = {{HALF_W{1'b0}}, memDataIn[HALF_W-1:0]};
    assign unused_bits = ^{memAddr[31:IXW+4], memAddr[2:0], memDataIn[TILE_W-1:HALF_W]};
`else
    assign req_half    = 1'b0;
    assign req_data    = memDataIn;
    assign unused_bits = ^{memAddr[31:IXW+4], memAddr[3:0], half_q};
`endif

    function automatic logic [1:0] ok_of(input state_e s);
        case (s)
            ST_IDLE: return UMEM_OK_READY;
            ST_BUSY: return UMEM_OK_HOLD;
            ST_DONE: return UMEM_OK_OK;
            default: return UMEM_OK_FAULT;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ix_d      = ix_q;
        wr_d      = wr_q;
        data_d    = data_q;
        dout_d    = dout_q;
        half_d    = half_q;
        ram_en    = 1'b0;
        ram_we    = 2'b00;
        ram_addr  = ix_q;
        ram_wdata = UV128_XX;

        case (state_q)
            ST_IDLE: begin
                ram_addr = req_ix;
                if (is_tile_req(memOpm)) begin
                    // Read the tile now so it is waiting when the latency expires.
                    ram_en  = 1'b1;
                    ix_d    = req_ix;
                    half_d  = req_half;
                    wr_d    = (memOpm == UMEM_OPM_WR_TILE);
                    data_d  = req_data;
                    cnt_d   = 8'(LATENCY);
                    state_d = ST_BUSY;
                end else if (memOpm != UMEM_OPM_READY) begin
                    state_d = ST_FAULT;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (memOpm == UMEM_OPM_READY) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 8'd1) begin
                    state_d = ST_DONE;
                    if (wr_q) begin
                        ram_en = 1'b1;
                        dout_d = data_q;
`ifdef MEM_TILE_RESP_BL64_EN
                        ram_we    = half_q ? 2'b10 : 2'b01;
                        ram_wdata = {data_q[HALF_W-1:0], data_q[HALF_W-1:0]};
`else
                        ram_we    = 2'b11;
                        ram_wdata = data_q;
`endif
                    end else begin
`ifdef MEM_TILE_RESP_BL64_EN
                        dout_d = {{HALF_W{1'b0}},
                                  half_q ? ram_rdata[TILE_W-1:HALF_W] : ram_rdata[HALF_W-1:0]};
`else
                        dout_d = ram_rdata;
`endif
                    end
                end
            end
            ST_DONE, ST_FAULT: begin
                if (memOpm == UMEM_OPM_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The response code trails the IDLE decision by one cycle; elsewhere it tracks the next state.
        ok_d = (state_q == ST_IDLE) ? UMEM_OK_READY : ok_of(state_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            ix_q    <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            dout_q  <= '0;
            ok_q    <= UMEM_OK_READY;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ix_q    <= ix_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
            ok_q    <= ok_d;
            half_q  <= half_d;
        end
    end

    mem_tile_resp_ram #(
        .AW (IXW)
    ) u_ram (
        .clk_i   (clock),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign memDataOut  = dout_q;
    assign memOK       = ok_q;
    assign dbg_state_o = state_q;

endmodule
